// File: rtl/spec_readout_if.sv
// spec_readout_if: frame control, DPRAM read port and
// output word stream of the spectrum readout block.
interface spec_readout_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [4:0]        num_rangebins;
  logic              rd_en;
  logic [13:0]       rdaddr_out;
  logic [DATA_W-1:0] dpram_dout;
  logic [DATA_W-1:0] dout;
  logic [3:0]        dout_slot;
  logic [9:0]        dout_bin;
  logic              dout_last;
  logic              dout_valid;
  logic              dout_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  start, num_rangebins, dpram_dout, dout_ready,
    output rd_en, rdaddr_out, dout, dout_slot, dout_bin,
    output dout_last, dout_valid, busy, done
  );

  modport master (
    output start, num_rangebins, dpram_dout, dout_ready,
    input  rd_en, rdaddr_out, dout, dout_slot, dout_bin,
    input  dout_last, dout_valid, busy, done
  );
endinterface

// File: rtl/spec_readout.sv
// spec_readout: walks slots x 1024 bins of the accumulation DPRAM
// and streams the words out through a credit-limited buffer.
module spec_readout #(
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 2,
  parameter int BUF_DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  spec_readout_if.slave bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);

  state_t            state_q, state_d;
  logic [4:0]        n_q, n_d;
  logic [3:0]        slot_q, slot_d;
  logic [9:0]        bin_q, bin_d;
  logic              rd_en_q, rd_en_d;
  logic [13:0]       addr_q, addr_d;
  logic              last_q, last_d;
  logic [PW-1:0]     wp_q, wp_d;
  logic [PW-1:0]     rp_q, rp_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [RD_LAT-1:0] pv_q;
  logic [RD_LAT-1:0] pl_q;
  logic [3:0]        ps_q [RD_LAT];
  logic [9:0]        pb_q [RD_LAT];

  logic [DATA_W-1:0]    md_q [BUF_DEPTH];
  logic [3:0]           ms_q [BUF_DEPTH];
  logic [9:0]           mb_q [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] ml_q;

  logic       push, pop, issue, is_last;
  logic [4:0] n_start, n_cur;
  logic [7:0] infl, credit;

  always_comb begin
    n_start = (bus.num_rangebins > 5'd16) ? 5'd16
                                          : bus.num_rangebins;
    n_cur   = (state_q == IDLE) ? n_start : n_q;
    push    = pv_q[RD_LAT-1];
    pop     = (cnt_q != '0) && bus.dout_ready;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    wp_d    = wp_q;
    rp_d    = rp_q;
    if (push)
      wp_d = (wp_q == PW'(BUF_DEPTH-1)) ? '0 : wp_q + PW'(1);
    if (pop)
      rp_d = (rp_q == PW'(BUF_DEPTH-1)) ? '0 : rp_q + PW'(1);
    // Credit counts state after this cycle's push/pop so a full
    // pipeline keeps one word per cycle flowing.
    infl = 8'(rd_en_q);
    for (int i = 0; i < RD_LAT-1; i++)
      infl = infl + 8'(pv_q[i]);
    credit  = infl + 8'(cnt_d);
    is_last = ({1'b0, slot_q} == n_cur - 5'd1) &&
              (bin_q == 10'd1023);
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    slot_d  = slot_q;
    bin_d   = bin_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          n_d     = n_start;
          issue   = (n_start != 5'd0);
          state_d = (n_start == 5'd0) ? FIN : READ;
        end
      end
      READ: begin
        issue = (credit < 8'(BUF_DEPTH));
        if (issue && is_last)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && ml_q[rp_q])
          state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
        slot_d  = '0;
        bin_d   = '0;
      end
      default: state_d = IDLE;
    endcase
    rd_en_d = issue;
    last_d  = issue && is_last;
    addr_d  = issue ? {slot_q, bin_q} : addr_q;
    if (issue) begin
      bin_d = bin_q + 10'd1;
      if (bin_q == 10'd1023)
        slot_d = slot_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      slot_q  <= '0;
      bin_q   <= '0;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      pv_q    <= '0;
      pl_q    <= '0;
      ml_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        ps_q[i] <= '0;
        pb_q[i] <= '0;
      end
      for (int i = 0; i < BUF_DEPTH; i++) begin
        md_q[i] <= '0;
        ms_q[i] <= '0;
        mb_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      slot_q  <= slot_d;
      bin_q   <= bin_d;
      rd_en_q <= rd_en_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      pv_q[0] <= rd_en_q;
      pl_q[0] <= last_q;
      ps_q[0] <= addr_q[13:10];
      pb_q[0] <= addr_q[9:0];
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pl_q[i] <= pl_q[i-1];
        ps_q[i] <= ps_q[i-1];
        pb_q[i] <= pb_q[i-1];
      end
      if (push) begin
        md_q[wp_q] <= bus.dpram_dout;
        ms_q[wp_q] <= ps_q[RD_LAT-1];
        mb_q[wp_q] <= pb_q[RD_LAT-1];
        ml_q[wp_q] <= pl_q[RD_LAT-1];
      end
    end
  end

  assign bus.rd_en      = rd_en_q;
  assign bus.rdaddr_out = addr_q;
  assign bus.dout       = md_q[rp_q];
  assign bus.dout_slot  = ms_q[rp_q];
  assign bus.dout_bin   = mb_q[rp_q];
  assign bus.dout_last  = ml_q[rp_q] && (cnt_q != '0);
  assign bus.dout_valid = (cnt_q != '0);
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == FIN);
endmodule

// File: tb/tb_spec_readout.sv
// tb_spec_readout: random frames against a queue-based reference
// of the slot/bin walk, with a DPRAM model and a decoupled monitor.
module tb_spec_readout;
  localparam int DATA_W    = 32;
  localparam int RD_LAT    = 2;
  localparam int BUF_DEPTH = 4;

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [3:0]        s;
    logic [9:0]        b;
    logic              l;
  } item_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spec_readout_if #(.DATA_W(DATA_W)) bus ();

  spec_readout #(
    .DATA_W(DATA_W), .RD_LAT(RD_LAT), .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int unsigned salt = 0;
  item_t exp_q[$];
  item_t mon_it;
  item_t stall_it;
  bit stall_v = 0;
  logic prev_busy = 0;

  int issued, popped, rd_cnt, done_cnt, done_cyc;
  int first_valid_cyc, first_pop_cyc, last_pop_cyc, busy_fall_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] word(input logic [13:0] a);
    if (salt == 0) return DATA_W'(a);
    return (DATA_W'(a) * 32'h9E37_79B1) ^ salt;
  endfunction

  // DPRAM read port with two cycles of latency.
  logic        ram_e;
  logic [13:0] ram_a;
  always @(posedge clk) begin
    ram_e <= bus.rd_en;
    ram_a <= bus.rdaddr_out;
    bus.dpram_dout <= ram_e ? word(ram_a) : 32'hDEAD_BEEF;
  end

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, req, cyc);
    end
  endtask

  function automatic longint pack(input item_t it);
    return {17'd0, it.l, it.s, it.b, it.d};
  endfunction

  task automatic clear_stats();
    issued = 0; popped = 0; rd_cnt = 0; done_cnt = 0;
    done_cyc = -1; first_valid_cyc = -1; first_pop_cyc = -1;
    last_pop_cyc = -1; busy_fall_cyc = -1;
  endtask

  task automatic push_exp(input int nc);
    item_t it;
    for (int s = 0; s < nc; s++)
      for (int b = 0; b < 1024; b++) begin
        it.s = 4'(s);
        it.b = 10'(b);
        it.d = word({4'(s), 10'(b)});
        it.l = (s == nc-1) && (b == 1023);
        exp_q.push_back(it);
      end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_v = 0;
      prev_busy = 0;
    end else begin
      if (bus.rd_en) begin
        chk(bus.rdaddr_out == 14'(rd_cnt), "rdaddr",
            bus.rdaddr_out, rd_cnt);
        rd_cnt++;
        issued++;
      end
      if (bus.busy)
        chk(issued - popped <= BUF_DEPTH, "outstanding",
            issued - popped, BUF_DEPTH);
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (prev_busy && !bus.busy) busy_fall_cyc = cyc;
      prev_busy = bus.busy;
      mon_it.d = bus.dout;
      mon_it.s = bus.dout_slot;
      mon_it.b = bus.dout_bin;
      mon_it.l = bus.dout_last;
      if (stall_v)
        chk(bus.dout_valid && pack(mon_it) == pack(stall_it),
            "stall_stable", pack(mon_it), pack(stall_it));
      stall_v = 0;
      if (bus.dout_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (bus.dout_ready) begin
          if (exp_q.size() == 0)
            chk(0, "unexpected_word", pack(mon_it), 0);
          else begin
            stall_it = exp_q.pop_front();
            chk(pack(mon_it) == pack(stall_it), "word",
                pack(mon_it), pack(stall_it));
          end
          if (popped == 0) first_pop_cyc = cyc;
          last_pop_cyc = cyc;
          popped++;
        end else begin
          stall_v = 1;
          stall_it = mon_it;
        end
      end
    end
  end

  task automatic check_reset_outputs();
    chk(bus.rd_en == 0, "rst_rd_en", bus.rd_en, 0);
    chk(bus.rdaddr_out == 0, "rst_rdaddr", bus.rdaddr_out, 0);
    chk(bus.dout == 0, "rst_dout", bus.dout, 0);
    chk(bus.dout_slot == 0, "rst_slot", bus.dout_slot, 0);
    chk(bus.dout_bin == 0, "rst_bin", bus.dout_bin, 0);
    chk(bus.dout_last == 0, "rst_last", bus.dout_last, 0);
    chk(bus.dout_valid == 0, "rst_valid", bus.dout_valid, 0);
    chk(bus.busy == 0, "rst_busy", bus.busy, 0);
    chk(bus.done == 0, "rst_done", bus.done, 0);
  endtask

  // mode 0: ready held high; mode 1: ready random 50%.
  task automatic run_frame(input int n, input int mode,
                           input int inject_at);
    int nc, c0, k, budget;
    bit injected;
    nc = (n > 16) ? 16 : n;
    budget = nc * 1024 * 4 + 50;
    injected = 0;
    clear_stats();
    push_exp(nc);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.num_rangebins = 5'(n);
    bus.dout_ready = (mode == 0) ? 1'b1 : 1'($urandom % 2);
    c0 = cyc;
    for (k = 0; k < budget && busy_fall_cyc < 0; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.num_rangebins = 5'($urandom);
      bus.dout_ready = (mode == 0) ? 1'b1 : 1'($urandom % 2);
      if (inject_at >= 0 && !injected && popped >= inject_at) begin
        bus.start = 1'b1;
        bus.num_rangebins = 5'd5;
        injected = 1;
      end
    end
    bus.start = 1'b0;
    chk(busy_fall_cyc >= 0, "frame_timeout", k, budget);
    chk(exp_q.size() == 0, "leftover", exp_q.size(), 0);
    chk(rd_cnt == nc * 1024, "rd_count", rd_cnt, nc * 1024);
    chk(popped == nc * 1024, "word_count", popped, nc * 1024);
    chk(done_cnt == 1, "done_count", done_cnt, 1);
    chk(busy_fall_cyc == done_cyc + 1, "busy_fall",
        busy_fall_cyc - c0, done_cyc + 1 - c0);
    if (nc == 0) begin
      chk(done_cyc - c0 == 1, "empty_done_cycle", done_cyc - c0, 1);
      chk(first_valid_cyc < 0, "empty_no_valid", first_valid_cyc, -1);
    end else begin
      chk(first_valid_cyc - c0 == 2 + RD_LAT, "first_valid_cycle",
          first_valid_cyc - c0, 2 + RD_LAT);
      chk(done_cyc == last_pop_cyc + 1, "done_after_last",
          done_cyc - c0, last_pop_cyc + 1 - c0);
      if (mode == 0)
        chk(last_pop_cyc - first_pop_cyc == nc * 1024 - 1, "no_gaps",
            last_pop_cyc - first_pop_cyc, nc * 1024 - 1);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_test();
    int k;
    salt = $urandom;
    clear_stats();
    exp_q.delete();
    push_exp(4);
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.num_rangebins = 5'd4;
    bus.dout_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (k = 0; k < 20000 && popped < 2 * 1024 + 296; k++) begin
      @(posedge clk); #1;
    end
    bus.dout_ready = 1'b0;
    chk(k < 20000, "mid_frame_timeout", k, 20000);
    repeat (12) @(posedge clk);
    #1;
    chk(bus.dout_valid == 1, "stall_valid", bus.dout_valid, 1);
    chk(bus.dout_slot == 4'd2, "stall_slot", bus.dout_slot, 2);
    chk(issued - popped == BUF_DEPTH, "stall_full",
        issued - popped, BUF_DEPTH);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.num_rangebins = 5'd0;
    bus.dout_ready = 1'b0;
    clear_stats();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst_n = 1'b1;
    salt = $urandom;
    run_frame(1, 0, -1);
    salt = 0;
    run_frame(16, 0, -1);
    salt = $urandom;
    run_frame(3, 1, -1);
    run_frame(0, 0, -1);
    salt = $urandom;
    run_frame(20, 0, -1);
    run_frame(2, 0, 500);
    reset_test();
    salt = $urandom;
    run_frame(1, 0, -1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spec_readout.md
# spec_readout

Reads accumulated power spectra out of the accumulation DPRAM and streams them to the host-side output FIFO once all pulses of a frame have been accumulated. It sits directly downstream of the spectrum accumulator:
- It uses that DPRAM's second read port, which holds one 1024-point spectrum per range-bin slot, addressed as {slot[3:0], bin[9:0]}.
- It walks slots 0..N-1, bins 0..1023, absorbs the RAM read latency, and honours valid/ready backpressure without losing or duplicating words.

## Interface
Parameters:
- DATA_W, 32, spectrum word width (matches DPRAM data width)
- RD_LAT, 2, DPRAM read latency in cycles from rd_en/address to valid dpram_dout
- BUF_DEPTH, 4, internal output buffer depth; must be ≥ RD_LAT+2

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin frame readout; ignored while busy=1
- num_rangebins  in  5  number of slots to read; sampled on accepted start; 0 = empty frame, values >16 clamp to 16
- rd_en  out  1  DPRAM read-port enable
- rdaddr_out  out  14  DPRAM read address {slot[3:0], bin[9:0]}
- dpram_dout  in  DATA_W  DPRAM read data, valid RD_LAT cycles after rd_en
- dout  out  DATA_W  output word (head of buffer)
- dout_slot  out  4  slot tag of dout
- dout_bin  out  10  bin tag of dout
- dout_last  out  1  high with the final word of the frame
- dout_valid  out  1  dout/tags valid
- dout_ready  in  1  consumer accepts word when dout_valid & dout_ready
- busy  out  1  readout in progress; accumulator writes must be held off while high
- done  out  1  one-cycle pulse at end of frame readout

## Operation
- State machine:
  - IDLE -> READ on start with clamped num_rangebins ≥ 1.
  - IDLE -> FIN on start with num_rangebins = 0.
  - READ -> DRAIN after the read of {N-1, 1023} is issued.
  - DRAIN -> FIN when no reads are in flight, the buffer is empty, and the last word has been accepted.
  - FIN -> IDLE unconditionally.
- busy = (state != IDLE). done = 1 for exactly the FIN cycle.
- Address generator: bin counter 0..1023 advances on each issued read. On wrap to 0 the slot counter increments. rdaddr_out = {slot, bin}, registered together with rd_en.
- Credit rule: a read issues in READ only when inflight + count < BUF_DEPTH.
  - inflight = reads issued whose data has not yet returned (0..RD_LAT).
  - count = buffer occupancy.
- Return path: an RD_LAT-deep shift register carries the valid flag, slot, bin and last flag alongside each read. When its output valid is high, dpram_dout plus tags are written into the buffer.
- Buffer is a FIFO. dout_valid = (count != 0). A pop occurs on dout_valid & dout_ready.
  - Simultaneous push and pop leaves count unchanged.
  - The credit rule guarantees no push into a full buffer. A push when full is an assertion failure in verification.
- dout_last = 1 only on the word tagged {N-1, 1023}.
- A start pulse while busy is dropped; the latched N is unchanged.
- Reset, including mid-frame: state IDLE, counters, inflight and buffer cleared. Any in-flight DPRAM data returning after reset is discarded.

## Timing
- Reset values: rd_en=0, rdaddr_out=0, dout=0, dout_slot=0, dout_bin=0, dout_last=0, dout_valid=0, busy=0, done=0.
- start is sampled in cycle 0. busy goes high in cycle 1. The first rd_en with rdaddr_out=0 is in cycle 1.
- First word: dpram_dout is valid in cycle 1+RD_LAT. dout_valid goes high in cycle 2+RD_LAT (cycle 4 at default).
- With dout_ready held at 1, throughput is one word per cycle with no bubbles. N=16 gives 16384 words in consecutive cycles.
- Last word of frame: done pulses in the cycle after it is accepted. busy falls in the cycle after done.
- Empty frame (N=0): busy high in cycle 1 (FIN), done=1 in cycle 1, idle in cycle 2, and rd_en never asserts.
- Backpressure: dout, the tags and dout_valid stay stable while dout_valid=1 and dout_ready=0. At most BUF_DEPTH words are held plus in flight.

## Test plan
- N=1, dout_ready=1: start at cycle 0 -> dout_valid first at cycle 4; 1024 consecutive words; bins 0..1023, slot 0; dout_last on bin 1023; done one cycle later; rd_en count = 1024.
- N=16, dout_ready=1, RAM preloaded with word = address -> 16384 words in order, dout == {slot, bin}; no gaps; dout_last only on {15,1023}.
- N=3, dout_ready random 50%:
  - every word is delivered exactly once, in order;
  - outputs stay stable while stalled;
  - buffer never overflows;
  - inflight + count ≤ 4 at all times.
- N=0 and N=20: N=0 -> done at cycle 1, no rd_en, no dout_valid. N=20 -> clamps to 16; 16384 words.
- Second start during busy at word 500 -> ignored; frame completes with the original N and a single done.
- rst_n asserted mid-frame (slot 2, bin 300, dout_ready=0 with buffer full) -> all outputs return to reset values immediately. A subsequent start with N=1 reads from address 0 with no stale words.
